alu_cmd_issuer: RTL and testbench

//  Synthesizable command front-end for the TinyALU family: buffers (op, A, B) instructions in a FIFO,

---
 rtl/tinyalu_pkg.sv | 16 +
 rtl/alu_cmd_fifo.sv | 35 +++
 rtl/alu_cmd_issuer.sv | 107 ++++++++++
 tb/tb_alu_cmd_issuer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared op encodings, legality check and issuer FSM states for the TinyALU front-end
package tinyalu_pkg;
    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100
    } operation_t;

    typedef enum logic [2:0] {IDLE, ISSUE, NOP, WAIT_LOW, HOLD} issuer_state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= mul_op;
    endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO of W-bit entries with occupancy count and async reset
module alu_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [W-1:0]                   wr_data,
    output logic [W-1:0]                   rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues (op, a, b) instructions, issues them over start/done and returns tagged results
module alu_cmd_issuer
    import tinyalu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [DATA_W-1:0]          in_a,
    input  logic [DATA_W-1:0]          in_b,
    output logic                       alu_start,
    output logic [2:0]                 alu_op,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    input  logic                       alu_done,
    input  logic [2*DATA_W-1:0]        alu_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*DATA_W-1:0]        out_result,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy
);
    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  tag;
    } entry_t;
    localparam int WD_W = $clog2(TIMEOUT+1);

    issuer_state_t state, next;
    entry_t head, push_entry;
    logic [TAG_W-1:0] tag;
    logic [WD_W-1:0] wd;
    logic full, empty, push, pop, timeout;

    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    assign pop        = state == IDLE && !empty;
    assign push_entry = {in_op, in_a, in_b, tag};
    assign timeout    = state == ISSUE && !alu_done && wd == WD_W'(TIMEOUT - 1);
    assign alu_start  = state == ISSUE || state == NOP;
    assign out_valid  = state == HOLD;
    assign busy       = state != IDLE || fifo_count != '0;

    alu_cmd_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .wr_data(push_entry),
        .rd_data(head),
        .full(full),
        .empty(empty),
        .count(fifo_count)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE:     if (!empty) next = head.op == no_op ? NOP : is_legal_op(head.op) ? ISSUE : HOLD;
            ISSUE:    next = alu_done ? WAIT_LOW : timeout ? HOLD : ISSUE;
            NOP:      next = IDLE;
            WAIT_LOW: if (!alu_done) next = HOLD;
            HOLD:     if (out_ready) next = IDLE;
            default:  next = IDLE;
        endcase
    end

    // Illegal ops never load the ALU-side registers, so the core sees nothing
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state      <= IDLE;
            tag        <= '0;
            wd         <= '0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            out_result <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
        end else begin
            state <= next;
            wd    <= state == ISSUE ? wd + 1'b1 : '0;
            if (push) tag <= tag + 1'b1;
            if (pop) begin
                out_tag    <= head.tag;
                out_err    <= !is_legal_op(head.op);
                out_result <= '0;
            end
            if (pop && is_legal_op(head.op)) begin
                alu_op <= head.op;
                alu_a  <= head.a;
                alu_b  <= head.b;
            end
            if (state == ISSUE && alu_done) out_result <= alu_result;
            if (timeout) out_err <= 1'b1;
        end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: randomized scoreboard bench with a behavioural ALU responder and result model
module tb_alu_cmd_issuer;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [15:0] result;
        logic [3:0]  tag;
        logic        err;
    } exp_t;
    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        bit         hang;
    } cmd_t;

    logic clk = 0, reset = 1;
    logic in_valid = 0, in_ready;
    logic [2:0] in_op = 0;
    logic [7:0] in_a = 0, in_b = 0;
    logic alu_start, alu_done = 0;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic [15:0] alu_result = 0;
    logic out_valid, out_ready = 0, out_err, busy;
    logic [15:0] out_result;
    logic [3:0] out_tag;
    logic [2:0] fifo_count;

    int checks = 0, errors = 0;
    exp_t exp_q[$];
    cmd_t cmd_q[$];
    logic [3:0] exp_tag = 0;
    bit hold_ready = 1;

    alu_cmd_issuer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_err(out_err), .fifo_count(fifo_count), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endfunction

    function automatic logic [15:0] alu_fn(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input bit hang);
        int g = 0;
        @(negedge clk);
        in_valid = 1; in_op = op; in_a = a; in_b = b;
        while (!in_ready && g < 500) begin @(negedge clk); g++; end
        if (!in_ready) begin
            check("push_accepted", 0, 1);
        end else begin
            @(posedge clk);
            if (op == 3'd0 || op <= 3'd4) cmd_q.push_back('{op, a, b, hang});
            if (op > 3'd4 || hang) exp_q.push_back('{16'h0000, exp_tag, 1'b1});
            else if (op != 3'd0) exp_q.push_back('{alu_fn(op, a, b), exp_tag, 1'b0});
            exp_tag++;
        end
        #1 in_valid = 0;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || cmd_q.size() != 0 || busy) && g < 3000) begin
            @(negedge clk); g++;
        end
        check("drain_within_budget", 32'(g < 3000), 1);
    endtask

    initial forever begin
        @(posedge clk); #1;
        out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Behavioural ALU: accepts each start, answers after a random latency unless hung or no_op
    initial begin
        bit active = 0;
        int cd = -1, high = 0, exp_high = 0;
        logic [15:0] res = 0;
        cmd_t c;
        forever begin
            @(posedge clk); #1;
            alu_done = 0;
            if (reset) begin
                active = 0;
            end else if (active) begin
                if (!alu_start) begin
                    check("start_high_cycles", high, exp_high);
                    active = 0;
                end else begin
                    high++;
                    if (cd == 0) begin alu_done = 1; alu_result = res; end
                    cd--;
                end
            end else if (alu_start) begin
                active = 1; high = 1;
                if (cmd_q.size() == 0) begin
                    check("unexpected_start", 1, 0);
                    cd = -1; exp_high = 0;
                end else begin
                    c = cmd_q.pop_front();
                    check("alu_op", alu_op, c.op);
                    check("alu_a", alu_a, c.a);
                    check("alu_b", alu_b, c.b);
                    res = alu_fn(c.op, c.a, c.b);
                    if (c.op == 3'd0) begin cd = -1; exp_high = 1; end
                    else if (c.hang) begin cd = -1; exp_high = TIMEOUT; end
                    else begin cd = $urandom_range(0, 3); exp_high = cd + 1; end
                    if (cd == 0) begin alu_done = 1; alu_result = res; end
                    cd--;
                end
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_result", out_result, e.result);
                check("out_tag", out_tag, e.tag);
                check("out_err", out_err, e.err);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_alu_start", alu_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_err", out_err, 0);
        reset = 0;
        hold_ready = 0;

        send(3'd1, 8'h12, 8'h34, 0);
        drain();

        hold_ready = 1;
        repeat (5) send(3'd4, 8'hFF, 8'hFF, 0);
        @(negedge clk);
        check("full_fifo_count", fifo_count, 4);
        check("full_in_ready", in_ready, 0);
        check("full_busy", busy, 1);
        repeat (20) @(negedge clk);
        hold_ready = 0;
        drain();

        send(3'd0, 8'h00, 8'h00, 0);
        send(3'd3, 8'hF0, 8'hFF, 0);
        drain();

        send(3'd7, 8'h11, 8'h22, 0);
        send(3'd1, 8'h01, 8'h02, 0);
        drain();

        send(3'd1, 8'h05, 8'h06, 1);
        send(3'd2, 8'h3C, 8'h0F, 0);
        drain();

        for (int i = 0; i < 40; i++)
            send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0);
        drain();

        hold_ready = 1;
        repeat (4) send(3'd1, 8'h01, 8'h01, 1);
        repeat (2) @(negedge clk);
        check("pre_reset_start", alu_start, 1);
        check("pre_reset_count", fifo_count, 3);
        reset = 1;
        #1;
        check("mid_reset_start", alu_start, 0);
        check("mid_reset_count", fifo_count, 0);
        check("mid_reset_valid", out_valid, 0);
        check("mid_reset_ready", in_ready, 1);
        exp_q.delete();
        cmd_q.delete();
        exp_tag = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        hold_ready = 0;
        send(3'd1, 8'h20, 8'h22, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
